mem_bus_interconnect: RTL and testbench

Parametrised successor to the hand-coded SoC address decoder and ready/rdata mux. It connects the single picorv32 native memory master to N_SLAVES slaves through a parameter-driven base/mask address map. It registers the slave select and adds a per-transaction timeout, so a hung or unmapped access gets an error response instead of stalling the CPU. It also records error status for the firmware.

---
 rtl/mem_bus_interconnect.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_interconnect.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_interconnect.sv
// mem_bus_interconnect
//   Connects one picorv32-style native memory master to N_SLAVES slaves.
//   Each slave owns an address window described by a base/mask pair. The
//   slave select is registered, and each transaction has a stall timeout.
//   Accesses that are unmapped or that hang get an error response, so the
//   CPU never stalls. The block also keeps error status for firmware.
//
// Ports
//   clk, reset  system clock, synchronous active-high reset
//   m_valid     master request valid
//   m_addr      master byte address
//   m_ready     transaction complete, to the master
//   m_rdata     read data, to the master
//   s_sel       one-hot slave select (registered)
//   s_ready     per-slave ready
//   s_rdata     per-slave read data, slot i at [DATA_W*i +: DATA_W]
//   bus_err     one-cycle pulse on each error response
//   err_addr    address of the most recent error
//   err_count   saturating count of error responses
module mem_bus_interconnect #(
    parameter int                      N_SLAVES   = 8,
    parameter int                      DATA_W     = 32,
    parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK = {N_SLAVES{32'hFFFF_FFFF}},
    parameter int                      TIMEOUT    = 255,
    parameter logic [DATA_W-1:0]       ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic [31:0]                m_addr,
    output logic                       m_ready,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [N_SLAVES-1:0]        s_sel,
    input  logic [N_SLAVES-1:0]        s_ready,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    output logic                       bus_err,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_count
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR, DONE} state_e;

    state_e              state_q, state_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;
    logic [DATA_W-1:0]   rd_arr [N_SLAVES];

    // Address decode. The scan runs from the highest slot down, so the
    // lowest-index hit is written last and wins on overlapping windows.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLAVES; i++) begin
            rd_arr[i] = s_rdata[DATA_W*i +: DATA_W];
        end
    end

    // Only the registered selection is considered. Ready from the other
    // slaves never reaches the master.
    assign sel_ready   = s_ready[idx_q];
    assign sel_rdata   = rd_arr[idx_q];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // State and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m_valid) begin
                    if (hit) begin
                        state_d        = ACTIVE;
                        idx_d          = hit_idx;
                        sel_d          = '0;
                        sel_d[hit_idx] = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ACTIVE: begin
                cnt_d = cnt_q + 1'b1;
                // If ready and the timeout occur together, ready wins.
                if (sel_ready) begin
                    state_d = DONE;
                    sel_d   = '0;
                end else if (!m_valid) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end else if (timeout_hit) begin
                    state_d = ERR;
                    sel_d   = '0;
                end
            end
            ERR: begin
                state_d    = DONE;
                err_addr_d = m_addr;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            DONE: begin
                // Absorbs the cycle in which the master still drives m_valid.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m_ready = 1'b0;
        m_rdata = '0;
        bus_err = 1'b0;
        case (state_q)
            ACTIVE: begin
                m_ready = sel_ready;
                m_rdata = sel_rdata;
            end
            ERR: begin
                m_ready = 1'b1;
                m_rdata = ERR_DATA;
                bus_err = 1'b1;
            end
            default: ;
        endcase
    end

    assign s_sel     = sel_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// tb_mem_bus_interconnect
//   Self-checking bench for mem_bus_interconnect with an 8-slot map and
//   TIMEOUT=4. It drives fixed vectors, a few scripted corner sequences and
//   randomized transactions, which are checked against a transaction-level
//   latency/response model.
module tb_mem_bus_interconnect;

    localparam int N  = 8;
    localparam int TO = 4;
    localparam logic [255:0] BASE_F = {
        32'h6000_0000, 32'h5000_0000, 32'h1000_0000, 32'h3000_0000,
        32'h2000_0000, 32'h1000_0000, 32'h0002_0000, 32'h0000_0000};
    localparam logic [255:0] MASK_F = {
        32'hFFFF_FFFC, 32'hF000_0000, 32'hFF00_0000, 32'hFFFF_FF00,
        32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_E000, 32'hFFFE_0000};

    logic         clk = 1'b0;
    logic         reset;
    logic         m_valid;
    logic [31:0]  m_addr;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic [7:0]   s_sel;
    logic [7:0]   s_ready;
    logic [255:0] s_rdata;
    logic         bus_err;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  m_cnt;
    logic [31:0] m_eaddr;

    always #5 clk = ~clk;

    mem_bus_interconnect #(
        .N_SLAVES  (N),
        .DATA_W    (32),
        .SLAVE_BASE(BASE_F),
        .SLAVE_MASK(MASK_F),
        .TIMEOUT   (TO),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .s_sel    (s_sel),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .bus_err  (bus_err),
        .err_addr (err_addr),
        .err_count(err_count)
    );

    typedef struct {
        logic [31:0] addr;
        int          w;
        logic [7:0]  spur;
        logic [7:0]  sel;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Lowest-index matching window, or -1 when the address is unmapped.
    function automatic int model_dec(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & MASK_F[32*i +: 32]) == BASE_F[32*i +: 32]) return i;
        end
        return -1;
    endfunction

    // Runs one transaction. It starts in an IDLE cycle just after a rising
    // edge and ends in the following IDLE cycle. The target slave raises
    // ready w cycles after select; spur drives the ready lines of all other
    // slaves.
    task automatic run_txn(input string nm, input logic [31:0] addr, input int w,
                           input logic [7:0] spur, input logic [7:0] esel,
                           input int ecyc, input logic [31:0] edata, input logic eerr);
        logic [31:0] sd;
        logic        act_e;
        logic [7:0]  sel_e;
        logic        rdy_e;
        logic        berr_e;
        logic [31:0] data_e;
        sd = '0;
        for (int i = 0; i < N; i++) if (esel[i]) sd = s_rdata[32*i +: 32];
        m_valid = 1'b1;
        m_addr  = addr;
        s_ready = '0;
        @(negedge clk);
        chk({nm, "_c0"}, {s_sel, m_ready, bus_err}, {8'h00, 1'b0, 1'b0});
        for (int k = 1; k <= ecyc; k++) begin
            @(posedge clk);
            #1;
            s_ready = spur & ~esel;
            if ((k - 1) == w) s_ready = s_ready | esel;
            @(negedge clk);
            act_e  = (esel != 0) && ((k < ecyc) || !eerr);
            sel_e  = act_e ? esel : 8'h00;
            rdy_e  = (k == ecyc);
            berr_e = eerr && (k == ecyc);
            data_e = rdy_e ? edata : (act_e ? sd : 32'h0);
            chk($sformatf("%s_c%0d", nm, k), {s_sel, m_ready, bus_err, m_rdata},
                {sel_e, rdy_e, berr_e, data_e});
        end
        @(posedge clk);
        #1;
        s_ready = '0;
        if (eerr) begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            m_eaddr = addr;
        end
        @(negedge clk);
        chk({nm, "_done"}, {s_sel, m_ready, bus_err, err_count, err_addr},
            {8'h00, 1'b0, 1'b0, m_cnt, m_eaddr});
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    task automatic run_rand(input int n);
        logic [31:0] a;
        logic [7:0]  esel;
        logic [31:0] ed;
        int          j, idx, w, ecyc;
        logic        eerr;
        for (int t = 0; t < n; t++) begin
            j = $urandom_range(0, N);
            if (j < N) a = BASE_F[32*j +: 32] | ($urandom & ~MASK_F[32*j +: 32]);
            else       a = $urandom;
            w   = $urandom_range(0, 7);
            idx = model_dec(a);
            if (idx < 0) begin
                esel = 8'h00; ecyc = 1; ed = 32'hDEAD_BEEF; eerr = 1'b1;
            end else begin
                esel = 8'h01 << idx;
                if (w <= TO) begin
                    ecyc = w + 1; ed = s_rdata[32*idx +: 32]; eerr = 1'b0;
                end else begin
                    ecyc = TO + 2; ed = 32'hDEAD_BEEF; eerr = 1'b1;
                end
            end
            run_txn($sformatf("rnd%0d", t), a, w, 8'($urandom), esel, ecyc, ed, eerr);
        end
    endtask

    initial begin
        tbl[0] = '{32'h0002_0010, 0,  8'h00, 8'h02, 1, 32'h1234_5678, 1'b0};
        tbl[1] = '{32'h4000_0000, 0,  8'hFF, 8'h00, 1, 32'hDEAD_BEEF, 1'b1};
        tbl[2] = '{32'h0000_1000, 4,  8'h00, 8'h01, 5, 32'hC0DE_0000, 1'b0};
        tbl[3] = '{32'h2000_0ABC, 99, 8'h00, 8'h08, 6, 32'hDEAD_BEEF, 1'b1};
        tbl[4] = '{32'h1000_0040, 2,  8'hFF, 8'h04, 3, 32'hC0DE_2222, 1'b0};
        tbl[5] = '{32'h10FF_0000, 1,  8'h00, 8'h20, 2, 32'hC0DE_5555, 1'b0};
        tbl[6] = '{32'h6000_0003, 0,  8'h5A, 8'h80, 1, 32'hC0DE_7777, 1'b0};
        tbl[7] = '{32'h6000_0004, 0,  8'hFF, 8'h00, 1, 32'hDEAD_BEEF, 1'b1};
        tbl[8] = '{32'h5ABC_DEF0, 3,  8'h00, 8'h40, 4, 32'hC0DE_6666, 1'b0};
        tbl[9] = '{32'h3000_00FF, 0,  8'h0F, 8'h10, 1, 32'hC0DE_4444, 1'b0};

        s_rdata = {32'hC0DE_7777, 32'hC0DE_6666, 32'hC0DE_5555, 32'hC0DE_4444,
                   32'hC0DE_3333, 32'hC0DE_2222, 32'h1234_5678, 32'hC0DE_0000};
        m_cnt   = 8'h00;
        m_eaddr = 32'h0;

        // Reset takes priority over a pending unmapped request.
        reset   = 1'b1;
        m_valid = 1'b1;
        m_addr  = 32'h4000_0000;
        s_ready = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", {s_sel, m_ready, bus_err, m_rdata, err_addr, err_count},
            {8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00});
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_valid = 1'b0;
        s_ready = '0;

        for (int v = 0; v < 10; v++) begin
            run_txn($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].w, tbl[v].spur,
                    tbl[v].sel, tbl[v].cyc, tbl[v].data, tbl[v].err);
        end

        // Master abandons the request while the slave stalls.
        m_valid = 1'b1;
        m_addr  = 32'h2000_0000;
        s_ready = '0;
        @(posedge clk); #1; @(negedge clk);
        chk("drop_c1", {s_sel, m_ready}, {8'h08, 1'b0});
        @(posedge clk); #1; m_valid = 1'b0; @(negedge clk);
        chk("drop_c2", {s_sel, m_ready}, {8'h08, 1'b0});
        @(posedge clk); #1; @(negedge clk);
        chk("drop_c3", {s_sel, m_ready, bus_err, err_count}, {8'h00, 1'b0, 1'b0, m_cnt});
        @(posedge clk); #1;

        run_rand(150);

        for (int t = 0; t < 300; t++) begin
            run_txn("unmapped", 32'h4000_0000 + 32'(t), 0, 8'h00, 8'h00, 1, 32'hDEAD_BEEF, 1'b1);
        end
        chk("err_count_sat", {56'h0, err_count}, 64'hFF);

        // Reset while a transaction is in ACTIVE.
        m_valid = 1'b1;
        m_addr  = 32'h0000_0100;
        s_ready = '0;
        @(posedge clk); #1; @(negedge clk);
        chk("rst_mid_c1", {s_sel, m_ready}, {8'h01, 1'b0});
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; m_valid = 1'b0;
        m_cnt   = 8'h00;
        m_eaddr = 32'h0;
        @(negedge clk);
        chk("rst_mid_after", {s_sel, m_ready, bus_err, err_count, err_addr},
            {8'h00, 1'b0, 1'b0, 8'h00, 32'h0});
        @(posedge clk); #1;
        run_txn("post_rst", tbl[0].addr, tbl[0].w, tbl[0].spur, tbl[0].sel,
                tbl[0].cyc, tbl[0].data, tbl[0].err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
